// File: rtl/transport_pkg.sv
// Shared encodings and FSM state types
// for the transport-layer packetizer.
package transport_pkg;

  typedef enum logic [1:0] {
    CMD_IDLE  = 2'b00,
    CMD_CTRL  = 2'b01,
    CMD_AUDIO = 2'b10,
    CMD_FLUSH = 2'b11
  } cmd_e;

  localparam logic [1:0] TYP_CTRL  = 2'b01;
  localparam logic [1:0] TYP_AUDIO = 2'b10;

  typedef enum logic [2:0] {
    W_IDLE,
    W_HDR0,
    W_HDR1,
    W_CTRL,
    W_PAY,
    W_PAD,
    W_COMMIT
  } wstate_e;

  typedef enum logic {
    R_IDLE,
    R_SEND
  } rstate_e;

endpackage

// File: rtl/pkt_queue_ram.sv
// Simple dual-port byte RAM holding whole packets:
// one write port, one registered read port with enable.
module pkt_queue_ram #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [7:0]    wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [7:0]    rdata_o
);

  logic [7:0] mem_q [DEPTH];
  logic [7:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Read data holds while re_i is low so a stalled byte stays stable.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)     rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/transport_packetizer.sv
// Builds fixed-length {type,seq,dest} packets from control words
// and audio samples, queues them whole and streams bytes out.
module transport_packetizer
  import transport_pkg::*;
#(
  parameter int PKT_BYTES  = 16,
  parameter int QUEUE_PKTS = 4,
  parameter int DATA_W     = 16,
  parameter int SEQ_W      = 6
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [1:0]                  in_cmd,
  input  logic [7:0]                  in_dest,
  input  logic [DATA_W-1:0]           in_data,
  input  logic                        send_en,
  output logic [7:0]                  out_byte,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        out_sop,
  output logic                        out_eop,
  output logic [$clog2(QUEUE_PKTS):0] pkt_count,
  output logic                        busy
);

  localparam int OFF_W = $clog2(PKT_BYTES);
  localparam int PTR_W = $clog2(QUEUE_PKTS);
  localparam int AW    = $clog2(QUEUE_PKTS * PKT_BYTES);
  localparam int CNT_W = $clog2(QUEUE_PKTS) + 1;
  localparam logic [OFF_W-1:0] LAST = OFF_W'(PKT_BYTES - 1);

  function automatic logic [AW-1:0] addr(
    input logic [PTR_W-1:0] p,
    input logic [OFF_W-1:0] o
  );
    return AW'(p) * AW'(PKT_BYTES) + AW'(o);
  endfunction

  wstate_e            wst_q;
  logic [OFF_W-1:0]   off_q;
  logic [1:0]         typ_q;
  logic [7:0]         dest_q;
  logic [DATA_W-1:0]  dat_q;
  logic               ph_q;
  logic [PTR_W-1:0]   wr_ptr_q;
  logic [SEQ_W-1:0]   cseq_q;
  logic [SEQ_W-1:0]   aseq_q;

  rstate_e            rs_q;
  logic [OFF_W-1:0]   roff_q;
  logic [PTR_W-1:0]   rd_ptr_q;
  logic [CNT_W-1:0]   cnt_q;

  cmd_e               cmd;
  logic               acc;
  logic               commit;
  logic               rd_done;
  logic               rd_start;
  logic               we;
  logic [7:0]         wbyte;
  logic               re;
  logic [AW-1:0]      raddr;
  logic [7:0]         rdata;
  logic [SEQ_W-1:0]   seq_sel;

  assign cmd     = cmd_e'(in_cmd);
  assign acc     = in_valid && in_ready;
  assign seq_sel = (typ_q == TYP_CTRL) ? cseq_q : aseq_q;
  assign commit  = (wst_q == W_COMMIT);
  assign rd_done = (rs_q == R_SEND) && out_ready
                && (roff_q == LAST);
  assign rd_start = (rs_q == R_IDLE) && (cnt_q != '0)
                 && send_en;

  // A control word arriving mid-audio is held off while the
  // open audio packet is closed out.
  always_comb begin
    in_ready = 1'b0;
    if (!reset) begin
      if (wst_q == W_IDLE)
        in_ready = cnt_q < CNT_W'(QUEUE_PKTS);
      else if (wst_q == W_PAY)
        in_ready = !ph_q && !(in_valid && cmd == CMD_CTRL);
    end
  end

  always_comb begin
    we    = 1'b0;
    wbyte = '0;
    unique case (wst_q)
      W_HDR0: begin
        we    = 1'b1;
        wbyte = 8'({typ_q, seq_sel});
      end
      W_HDR1: begin
        we    = 1'b1;
        wbyte = dest_q;
      end
      W_CTRL: begin
        we    = 1'b1;
        wbyte = ph_q ? dat_q[7:0] : dat_q[15:8];
      end
      W_PAY: begin
        if (ph_q) begin
          we    = 1'b1;
          wbyte = dat_q[7:0];
        end else if (acc && cmd == CMD_AUDIO) begin
          we    = 1'b1;
          wbyte = in_data[15:8];
        end
      end
      W_PAD:   we = 1'b1;
      default: we = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wst_q    <= W_IDLE;
      off_q    <= '0;
      typ_q    <= '0;
      dest_q   <= '0;
      dat_q    <= '0;
      ph_q     <= 1'b0;
      wr_ptr_q <= '0;
      cseq_q   <= '0;
      aseq_q   <= '0;
    end else begin
      unique case (wst_q)
        W_IDLE: begin
          if (acc && (cmd == CMD_CTRL
                   || cmd == CMD_AUDIO)) begin
            typ_q  <= in_cmd;
            dest_q <= in_dest;
            dat_q  <= in_data;
            off_q  <= '0;
            wst_q  <= W_HDR0;
          end
        end
        W_HDR0: begin
          off_q <= off_q + 1'b1;
          wst_q <= W_HDR1;
        end
        W_HDR1: begin
          off_q <= off_q + 1'b1;
          ph_q  <= 1'b0;
          wst_q <= W_CTRL;
        end
        W_CTRL: begin
          off_q <= off_q + 1'b1;
          ph_q  <= !ph_q;
          if (ph_q) begin
            if (off_q == LAST)         wst_q <= W_COMMIT;
            else if (typ_q == TYP_CTRL) wst_q <= W_PAD;
            else                       wst_q <= W_PAY;
          end
        end
        W_PAY: begin
          if (ph_q) begin
            off_q <= off_q + 1'b1;
            ph_q  <= 1'b0;
            if (off_q == LAST) wst_q <= W_COMMIT;
          end else if (in_valid && cmd == CMD_CTRL) begin
            wst_q <= W_PAD;
          end else if (acc && cmd == CMD_AUDIO) begin
            dat_q <= in_data;
            off_q <= off_q + 1'b1;
            ph_q  <= 1'b1;
          end else if (acc && cmd == CMD_FLUSH) begin
            wst_q <= W_PAD;
          end
        end
        W_PAD: begin
          off_q <= off_q + 1'b1;
          if (off_q == LAST) wst_q <= W_COMMIT;
        end
        W_COMMIT: begin
          wr_ptr_q <= wr_ptr_q + 1'b1;
          if (typ_q == TYP_CTRL) cseq_q <= cseq_q + 1'b1;
          else                   aseq_q <= aseq_q + 1'b1;
          wst_q <= W_IDLE;
        end
        default: wst_q <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rs_q     <= R_IDLE;
      roff_q   <= '0;
      rd_ptr_q <= '0;
    end else begin
      unique case (rs_q)
        R_IDLE: begin
          if (rd_start) begin
            roff_q <= '0;
            rs_q   <= R_SEND;
          end
        end
        R_SEND: begin
          if (out_ready) begin
            if (roff_q == LAST) begin
              rd_ptr_q <= rd_ptr_q + 1'b1;
              rs_q     <= R_IDLE;
            end else begin
              roff_q <= roff_q + 1'b1;
            end
          end
        end
        default: rs_q <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                   cnt_q <= '0;
    else if (commit && !rd_done) cnt_q <= cnt_q + 1'b1;
    else if (!commit && rd_done) cnt_q <= cnt_q - 1'b1;
  end

  assign re = rd_start
           || ((rs_q == R_SEND) && out_ready && (roff_q != LAST));
  assign raddr = addr(rd_ptr_q, rd_start ? '0 : roff_q + 1'b1);

  pkt_queue_ram #(
    .DEPTH (QUEUE_PKTS * PKT_BYTES),
    .AW    (AW)
  ) u_ram (
    .clk_i   (clk),
    .rst_i   (reset),
    .we_i    (we),
    .waddr_i (addr(wr_ptr_q, off_q)),
    .wdata_i (wbyte),
    .re_i    (re),
    .raddr_i (raddr),
    .rdata_o (rdata)
  );

  assign out_valid = (rs_q == R_SEND);
  assign out_byte  = out_valid ? rdata : '0;
  assign out_sop   = out_valid && (roff_q == '0);
  assign out_eop   = out_valid && (roff_q == LAST);
  assign pkt_count = cnt_q;
  assign busy      = (wst_q != W_IDLE) || (rs_q != R_IDLE);

endmodule

// File: tb/tb_transport_packetizer.sv
// Scoreboard bench for transport_packetizer: expected bytes are
// queued at stimulus time and popped by an output monitor.
module tb_transport_packetizer;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_cmd;
  logic [7:0]  in_dest;
  logic [15:0] in_data;
  logic        send_en;
  logic [7:0]  out_byte;
  logic        out_valid;
  logic        out_ready;
  logic        out_sop;
  logic        out_eop;
  logic [2:0]  pkt_count;
  logic        busy;

  always #5 clk = ~clk;

  transport_packetizer dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_cmd    (in_cmd),
    .in_dest   (in_dest),
    .in_data   (in_data),
    .send_en   (send_en),
    .out_byte  (out_byte),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sop   (out_sop),
    .out_eop   (out_eop),
    .pkt_count (pkt_count),
    .busy      (busy)
  );

  typedef struct packed {
    logic [7:0] b;
    logic       sop;
    logic       eop;
  } exp_t;

  exp_t       expq[$];
  logic [7:0] pay[$];
  int         n_vec = 0;
  int         n_err = 0;
  int         pc_max = 0;
  logic       held = 1'b0;
  logic [7:0] held_b = '0;
  logic       rnd_rdy = 1'b0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  function automatic void pushb(input logic [7:0] b, input int i);
    exp_t e;
    e.b   = b;
    e.sop = (i == 0);
    e.eop = (i == 15);
    expq.push_back(e);
  endfunction

  function automatic void push_pkt(input logic [7:0] hdr,
                                   input logic [7:0] dst);
    logic [7:0] b;
    for (int i = 0; i < 16; i++) begin
      if (i == 0)                b = hdr;
      else if (i == 1)           b = dst;
      else if (i - 2 < pay.size()) b = pay[i-2];
      else                       b = 8'h00;
      pushb(b, i);
    end
    pay.delete();
  endfunction

  function automatic void add_s(input logic [15:0] s);
    pay.push_back(s[15:8]);
    pay.push_back(s[7:0]);
  endfunction

  task automatic send(input logic [1:0] c,
                      input logic [7:0] d,
                      input logic [15:0] w);
    int   t;
    logic ok;
    t  = 0;
    ok = 1'b0;
    in_valid = 1'b1;
    in_cmd   = c;
    in_dest  = d;
    in_data  = w;
    while (!ok && t < 300) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      t++;
    end
    in_valid = 1'b0;
    chk("send_accept", 32'(ok), 32'd1);
  endtask

  task automatic wait_drain(input string nm);
    int   t;
    logic ok;
    t  = 0;
    ok = 1'b0;
    while (!ok && t < 4000) begin
      @(negedge clk);
      ok = (expq.size() == 0) && (pkt_count == 0) && !busy;
      t++;
    end
    chk({nm, "_drain"}, 32'(ok), 32'd1);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      held = 1'b0;
    end else begin
      if (held) begin
        n_vec++;
        if (!out_valid || out_byte !== held_b) begin
          n_err++;
          $display("FAIL hold: got v=%0b %02h expected v=1 %02h",
                   out_valid, out_byte, held_b);
        end
      end
      if (out_valid && out_ready) begin
        n_vec++;
        held = 1'b0;
        if (expq.size() == 0) begin
          n_err++;
          $display("FAIL extra_byte: got %02h expected none",
                   out_byte);
        end else begin
          e = expq.pop_front();
          if (out_byte !== e.b || out_sop !== e.sop
              || out_eop !== e.eop) begin
            n_err++;
            $display("FAIL byte: got %02h s%0b e%0b expected %02h s%0b e%0b",
                     out_byte, out_sop, out_eop, e.b, e.sop, e.eop);
          end
        end
      end else if (out_valid) begin
        held   = 1'b1;
        held_b = out_byte;
      end else begin
        held = 1'b0;
      end
      if (int'(pkt_count) > pc_max) pc_max = int'(pkt_count);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] t1 [16];
    logic       ok;
    int         t;
    t1 = '{8'h40, 8'h07, 8'hBE, 8'hEF, 8'h00, 8'h00, 8'h00, 8'h00,
           8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_cmd    = 2'b00;
    in_dest   = '0;
    in_data   = '0;
    send_en   = 1'b1;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd0);
    chk("rst_count", 32'(pkt_count), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_sop", 32'(out_sop), 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("idle_ready", 32'(in_ready), 32'd1);

    // single control packet
    for (int i = 0; i < 16; i++) pushb(t1[i], i);
    send(2'b01, 8'h07, 16'hBEEF);
    wait_drain("ctrl1");

    // seven audio samples fill one packet
    pc_max = 0;
    for (int s = 1; s <= 7; s++) add_s(16'(s));
    push_pkt(8'h80, 8'h22);
    for (int s = 1; s <= 7; s++) send(2'b10, 8'h22, 16'(s));
    wait_drain("audio7");
    chk("audio7_pcmax", 32'(pc_max), 32'd1);

    // eighth sample opens the next audio packet, flushed
    add_s(16'h0008);
    push_pkt(8'h81, 8'h23);
    send(2'b10, 8'h23, 16'h0008);
    send(2'b11, 8'h00, 16'h0000);
    wait_drain("audio_flush");

    // flush and idle words while idle do nothing
    send(2'b11, 8'h00, 16'h0000);
    send(2'b00, 8'h00, 16'h0000);
    repeat (5) @(posedge clk);
    #1;
    chk("noop_count", 32'(pkt_count), 32'd0);
    chk("noop_busy", 32'(busy), 32'd0);

    // control word closes an open audio packet
    add_s(16'h0A0B);
    add_s(16'h0C0D);
    add_s(16'h0E0F);
    push_pkt(8'h82, 8'h33);
    add_s(16'h1234);
    push_pkt(8'h41, 8'h44);
    send(2'b10, 8'h33, 16'h0A0B);
    send(2'b10, 8'h33, 16'h0C0D);
    send(2'b10, 8'h33, 16'h0E0F);
    send(2'b01, 8'h44, 16'h1234);
    wait_drain("implicit_flush");

    // queue full backpressure
    send_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      add_s(16'h5000 + 16'(i));
      push_pkt(8'h42 + 8'(i), 8'h50 + 8'(i));
    end
    for (int i = 0; i < 4; i++)
      send(2'b01, 8'h50 + 8'(i), 16'h5000 + 16'(i));
    in_valid = 1'b1;
    in_cmd   = 2'b01;
    in_dest  = 8'h54;
    in_data  = 16'h5004;
    repeat (25) @(posedge clk);
    @(negedge clk);
    chk("full_ready", 32'(in_ready), 32'd0);
    chk("full_count", 32'(pkt_count), 32'd4);
    @(posedge clk);
    #1;
    send_en = 1'b1;
    send(2'b01, 8'h54, 16'h5004);
    wait_drain("full");

    // random output backpressure
    rnd_rdy = 1'b1;
    fork
      begin
        while (rnd_rdy) begin
          @(posedge clk);
          #1;
          if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
        end
      end
    join_none
    t1[0] = 8'h47;
    for (int i = 0; i < 16; i++) pushb(t1[i], i);
    send(2'b01, 8'h07, 16'hBEEF);
    wait_drain("rand_ready");
    rnd_rdy = 1'b0;
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    @(posedge clk);
    #1;

    // reset mid-send and mid-audio
    add_s(16'hCAFE);
    push_pkt(8'h48, 8'h66);
    send(2'b01, 8'h66, 16'hCAFE);
    t  = 0;
    ok = 1'b0;
    while (!ok && t < 100) begin
      @(negedge clk);
      ok = out_valid;
      t++;
    end
    chk("pre_rst_valid", 32'(ok), 32'd1);
    @(posedge clk);
    #1;
    send(2'b10, 8'h67, 16'h1111);
    send(2'b10, 8'h67, 16'h2222);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    @(posedge clk);
    #3;
    reset = 1'b1;
    expq.delete();
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_byte", 32'(out_byte), 32'd0);
    chk("mid_rst_sop", 32'(out_sop), 32'd0);
    chk("mid_rst_count", 32'(pkt_count), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    add_s(16'h0001);
    push_pkt(8'h40, 8'h01);
    send(2'b01, 8'h01, 16'h0001);
    add_s(16'h0002);
    push_pkt(8'h80, 8'h02);
    send(2'b10, 8'h02, 16'h0002);
    send(2'b11, 8'h00, 16'h0000);
    wait_drain("post_rst");

    // 64 control packets wrap the control seq
    for (int i = 0; i < 64; i++) begin
      add_s(16'(i * 257));
      push_pkt(8'h40 | 8'((i + 1) % 64), 8'(i));
      send(2'b01, 8'(i), 16'(i * 257));
    end
    wait_drain("seq_wrap");

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
